mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Initiator side of the data-memory port in the P5 pipeline; sits in the MEM stage between the pipeline registers and the word-addressed data memory.
- Converts MEM-stage load/store ops (lw/lh/lhu/lb/lbu/sw/sh/sb) into word-addressed memory requests with byte enables, using a req/gnt + rvalid handshake.
- Sign/zero-extends returned load data, stalls the pipeline while a transaction is outstanding, and flags misaligned, out-of-range or timed-out accesses.

Parameters:
- ADDR_W, 10, memory word-address width; the byte address uses bits [ADDR_W+1:2].
- TIMEOUT, 255, maximum cycles in ISSUE or WAIT before BusErr is raised.

Ports:
- Clk  in  1  clock
- Reset  in  1  reset; synchronous, active-high
- MemValid  in  1  MEM stage holds a memory op
- MemOp  in  3  op code (package constants)
- ALUOutM  in  32  byte address
- WriteDataM  in  32  store source register value
- StallM  out  1  hold IF..MEM stages
- LoadData  out  32  extended load result
- LoadValid  out  1  LoadData valid, one cycle
- AdErr  out  1  alignment/range error pulse
- BusErr  out  1  timeout error pulse
- MemReq  out  1  request to memory
- MemWe  out  1  1=store, 0=load
- MemAddr  out  ADDR_W  word address
- MemBe  out  4  byte enables, bit i = byte lane i (little-endian)
- MemWData  out  32  lane-replicated store data
- MemGnt  in  1  memory accepted request this cycle
- MemRValid  in  1  read data valid
- MemRData  in  32  read word

Behaviour:
- Reset: state IDLE, timeout counter 0. All outputs except StallM are 0; StallM is 0 in IDLE with MemValid=0. Reset mid-transaction drops MemReq in the same edge with no completion pulse; the memory shares Reset.
- State machine: IDLE -> ISSUE -> (store) DONE | (load) WAIT -> DONE -> IDLE.
- IDLE
  - With MemValid and a legal access: latch op, MemAddr=ALUOutM[ADDR_W+1:2], MemBe, MemWData and byte offset; go to ISSUE.
  - With an illegal access: pulse AdErr for 1 cycle, issue no request, stay in IDLE.
- ISSUE
  - MemReq=1; MemWe/MemAddr/MemBe/MemWData held stable until MemGnt.
  - On MemGnt: store -> DONE; load -> WAIT.
  - MemRValid arriving in the same cycle as MemGnt is accepted; load goes straight to DONE.
- WAIT: MemReq=0; on MemRValid capture MemRData and go to DONE.
- DONE: exactly 1 cycle. StallM=0; for loads LoadValid=1 with LoadData; then IDLE. The pipeline advances on this edge, and the next op is sampled in the following IDLE cycle.
- StallM = (IDLE & MemValid & legal) | ISSUE | WAIT. Combinational, so a legal op stalls in its first cycle.
- Illegal access:
  - lh/lhu/sh with ALUOutM[0]=1.
  - lw/sw with ALUOutM[1:0]!=0.
  - ALUOutM[31:ADDR_W+2] nonzero.
  - AdErr is combinational in IDLE; StallM=0 so the pipeline proceeds and the exception logic takes over.
- Store byte enables:
  - sw: Be=1111, WData=data.
  - sh: Be = off[1] ? 1100 : 0011; WData = {2{data[15:0]}}.
  - sb: Be = 0001 << off; WData = {4{data[7:0]}}.
- Load extraction (using the latched offset):
  - lw: whole word.
  - lh/lhu: halfword at off[1]; sign- or zero-extended.
  - lb/lbu: byte at off; sign- or zero-extended.
- Timeout:
  - Counter clears on entering ISSUE, increments in ISSUE/WAIT, and is not reset between ISSUE and WAIT.
  - On reaching TIMEOUT: BusErr pulse, LoadValid=0, go to IDLE.
  - The stall releases in that IDLE cycle only if MemValid has dropped; otherwise the op re-issues.
- MemValid deasserting while in ISSUE/WAIT is ignored; the transaction completes.

Decomposition:
- Package mem_access_pkg:
  - MemOp encoding OP_LW=0, OP_LH=1, OP_LHU=2, OP_LB=3, OP_LBU=4, OP_SW=5, OP_SH=6, OP_SB=7.
  - FSM state encoding.
  - is_store/is_half/is_byte helper constants.
- One sub-module, load_extend: combinational (word, offset, op) -> 32-bit extended result. The parent holds the FSM, request datapath and counter.

Test Plan:
- sw addr 0x0000_0010, data 0xDEADBEEF, MemGnt on 2nd ISSUE cycle -> MemAddr=4, Be=1111, StallM high 3 cycles, DONE 1 cycle, no LoadValid.
- sb addr 0x13, data 0x000000A5 -> Be=1000, WData=0xA5A5A5A5; sh addr 0x12, data 0x1234 -> Be=1100, WData=0x12341234.
- Memory word 0x8001_80FF at addr 0x20:
  - lb 0x20 -> 0xFFFFFFFF
  - lbu 0x20 -> 0x000000FF
  - lh 0x22 -> 0xFFFF8001
  - lhu 0x22 -> 0x00008001
  - Each with LoadValid for exactly 1 cycle.
- lw 0x02 and sh 0x05 -> AdErr 1 cycle, MemReq never asserted, StallM 0. Address 0x0000_1000 with ADDR_W=10 -> AdErr.
- Load with MemGnt given and MemRValid withheld -> BusErr after TIMEOUT cycles, state IDLE, LoadValid stays 0.
- Reset asserted while in WAIT -> next cycle MemReq=0, StallM=0, no LoadValid. A subsequent lw completes normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage data-memory initiator.
package mem_access_pkg;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    function automatic logic is_store(input logic [2:0] op);
        return op == OP_SW || op == OP_SH || op == OP_SB;
    endfunction

    function automatic logic is_word(input logic [2:0] op);
        return op == OP_LW || op == OP_SW;
    endfunction

    function automatic logic is_half(input logic [2:0] op);
        return op == OP_LH || op == OP_LHU || op == OP_SH;
    endfunction

    function automatic logic is_byte(input logic [2:0] op);
        return op == OP_LB || op == OP_LBU || op == OP_SB;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Selects the addressed lane of a read word and sign/zero-extends it.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  op_i,
    output logic [31:0] data_o
);

    logic [15:0] half;
    logic [7:0]  b8;

    always_comb begin
        half   = off_i[1] ? word_i[31:16] : word_i[15:0];
        b8     = 8'(word_i >> {off_i, 3'b000});
        data_o = word_i;
        case (op_i)
            OP_LH:   data_o = {{16{half[15]}}, half};
            OP_LHU:  data_o = {16'd0, half};
            OP_LB:   data_o = {{24{b8[7]}}, b8};
            OP_LBU:  data_o = {24'd0, b8};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: turns load/store ops into req/gnt + rvalid
// transactions, stalls the pipeline and flags address and bus errors.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MemValid,
    input  logic [2:0]        MemOp,
    input  logic [31:0]       ALUOutM,
    input  logic [31:0]       WriteDataM,
    output logic              StallM,
    output logic [31:0]       LoadData,
    output logic              LoadValid,
    output logic              AdErr,
    output logic              BusErr,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [3:0]        MemBe,
    output logic [31:0]       MemWData,
    input  logic              MemGnt,
    input  logic              MemRValid,
    input  logic [31:0]       MemRData
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         op_q;
    logic [1:0]         off_q;
    logic               req_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [3:0]         be_q;
    logic [31:0]        wdata_q;
    logic               ldv_q;
    logic [31:0]        ldata_q;
    logic               buserr_q;

    logic [CNT_W-1:0]   cnt_d;
    logic [3:0]         be_d;
    logic [31:0]        wdata_d;
    logic [31:0]        ext;
    logic               misalign;
    logic               range_err;
    logic               legal;
    logic               idle;
    logic               expired;

    assign misalign  = (is_half(MemOp) && ALUOutM[0]) ||
                       (is_word(MemOp) && ALUOutM[1:0] != 2'b00);
    assign range_err = (ALUOutM >> (ADDR_W + 2)) != 32'd0;
    assign legal     = !misalign && !range_err;
    assign idle      = state_q == S_IDLE;
    assign cnt_d     = cnt_q + CNT_W'(1);
    assign expired   = cnt_d == TO_CNT;

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = WriteDataM;
        if (is_half(MemOp)) begin
            be_d    = ALUOutM[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{WriteDataM[15:0]}};
        end else if (is_byte(MemOp)) begin
            be_d    = 4'b0001 << ALUOutM[1:0];
            wdata_d = {4{WriteDataM[7:0]}};
        end
    end

    load_extend u_ext (
        .word_i (MemRData),
        .off_i  (off_q),
        .op_i   (op_q),
        .data_o (ext)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            off_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            ldv_q    <= 1'b0;
            ldata_q  <= '0;
            buserr_q <= 1'b0;
        end else begin
            ldv_q    <= 1'b0;
            ldata_q  <= '0;
            buserr_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (MemValid && legal) begin
                        state_q <= S_ISSUE;
                        cnt_q   <= '0;
                        op_q    <= MemOp;
                        off_q   <= ALUOutM[1:0];
                        req_q   <= 1'b1;
                        we_q    <= is_store(MemOp);
                        addr_q  <= ALUOutM[ADDR_W+1:2];
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                    end
                end
                S_ISSUE: begin
                    cnt_q <= cnt_d;
                    if (MemGnt) begin
                        req_q <= 1'b0;
                        if (we_q) begin
                            state_q <= S_DONE;
                        end else if (MemRValid) begin
                            state_q <= S_DONE;
                            ldv_q   <= 1'b1;
                            ldata_q <= ext;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end else if (expired) begin
                        req_q    <= 1'b0;
                        buserr_q <= 1'b1;
                        state_q  <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_d;
                    if (MemRValid) begin
                        state_q <= S_DONE;
                        ldv_q   <= 1'b1;
                        ldata_q <= ext;
                    end else if (expired) begin
                        buserr_q <= 1'b1;
                        state_q  <= S_IDLE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Address errors are reported in the op's own cycle without stalling.
    assign AdErr     = idle && MemValid && !legal;
    assign StallM    = (idle && MemValid && legal) ||
                       state_q == S_ISSUE || state_q == S_WAIT;
    assign MemReq    = req_q;
    assign MemWe     = we_q;
    assign MemAddr   = addr_q;
    assign MemBe     = be_q;
    assign MemWData  = wdata_q;
    assign LoadValid = ldv_q;
    assign LoadData  = ldata_q;
    assign BusErr    = buserr_q;

endmodule
